// File: rtl/simple_fpga_cvs_pkg.sv
// Shared sizing helpers for the simple FPGA clock divider.
// Widths are derived from the divide ratio and the start-up hold-off length.
package simple_fpga_cvs_pkg;
   timeunit 1ps;
   timeprecision 10fs;

   function automatic int cnt_width(input int divide);
      int w;
      w = $clog2(divide);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int hold_width(input int start_delay);
      int w;
      w = $clog2(start_delay + 1);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic bit is_odd(input int d);
      return (d % 2) == 1;
   endfunction

   // Rising-edge high count: D/2 for even D, (D-1)/2 for odd D.
   function automatic int high_cnt(input int d);
      return d / 2;
   endfunction
endpackage

// File: rtl/clk_div_core.sv
// Integer clock divider with 50% duty cycle for both even and odd ratios.
// Odd ratios stretch the high phase by half a period with a falling-edge flop.
module clk_div_core
   import simple_fpga_cvs_pkg::*;
#(
   parameter int DIVIDE = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   output logic clock_out
);
   timeunit 1ps;
   timeprecision 10fs;

   localparam int             CW   = cnt_width(DIVIDE);
   localparam logic [CW-1:0]  LAST = CW'(DIVIDE - 1);
   localparam logic [CW-1:0]  HIGH = CW'(high_cnt(DIVIDE));

   logic [CW-1:0] cnt;
   logic          q_pos;

   if (DIVIDE < 2) begin : g_bad_divide
      $error("clk_div_core: DIVIDE must be >= 2");
   end

   // NOTE: non-blocking assignments so q_pos samples the pre-edge count value.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         q_pos <= 1'b0;
      end else if (run) begin
         q_pos <= (cnt < HIGH);
         cnt   <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

   if (is_odd(DIVIDE)) begin : g_odd
      logic q_neg;

      // NOTE: q_neg changes only on falling edges and q_pos only on rising
      // edges, so the OR below can never glitch.
      always_ff @(negedge clock or posedge reset) begin
         if (reset) q_neg <= 1'b0;
         else       q_neg <= q_pos;
      end

      assign clock_out = q_pos | q_neg;
   end else begin : g_even
      assign clock_out = q_pos;
   end
endmodule

// File: rtl/simple_fpga_cvs.sv
// Top-level clock generation: holds clock_out low for START_DELAY rising
// edges after reset, then runs the divider.
module simple_fpga_cvs
   import simple_fpga_cvs_pkg::*;
#(
   parameter int DIVIDE      = 4,
   parameter int START_DELAY = 2
) (
   input  logic clock,
   input  logic reset,
   output logic clock_out
);
   timeunit 1ps;
   timeprecision 10fs;

   localparam int             HW       = hold_width(START_DELAY);
   localparam logic [HW-1:0]  HOLD_END = HW'(START_DELAY);

   logic [HW-1:0] hold_cnt;
   logic          run;

   // Saturates at START_DELAY; with START_DELAY=0 run is high from reset release.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)     hold_cnt <= '0;
      else if (!run) hold_cnt <= hold_cnt + HW'(1);
   end

   assign run = (hold_cnt == HOLD_END);

   clk_div_core #(
      .DIVIDE (DIVIDE)
   ) u_core (
      .clock     (clock),
      .reset     (reset),
      .run       (run),
      .clock_out (clock_out)
   );
endmodule

// File: tb/tb_simple_fpga_cvs.sv
// Scoreboard bench for simple_fpga_cvs: four dividers (4/2, 3/0, 2/0, 5/1)
// share one clock and reset; expectations come from a half-period timing model.
module tb_simple_fpga_cvs;
   timeunit 1ps;
   timeprecision 10fs;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic co4, co3, co2, co5;

   simple_fpga_cvs #(.DIVIDE(4), .START_DELAY(2)) u_d4 (.clock(clock), .reset(reset), .clock_out(co4));
   simple_fpga_cvs #(.DIVIDE(3), .START_DELAY(0)) u_d3 (.clock(clock), .reset(reset), .clock_out(co3));
   simple_fpga_cvs #(.DIVIDE(2), .START_DELAY(0)) u_d2 (.clock(clock), .reset(reset), .clock_out(co2));
   simple_fpga_cvs #(.DIVIDE(5), .START_DELAY(1)) u_d5 (.clock(clock), .reset(reset), .clock_out(co5));

   always #1 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int epoch    = 0;
   bit count_on = 1'b0;
   int pulses5  = 0;

   task automatic check_vec(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got {d4,d3,d2,d5}=%b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic check_real(input string name, input real act, input real exp);
      real diff;
      diff = act - exp;
      n_checks++;
      if (diff < -0.05 || diff > 0.05) begin
         n_fail++;
         $display("FAIL %s @%0t: got %f ps expected %f ps", name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference: counting half-periods from the first rising edge after hold-off,
   // the output is high for the first d half-periods of every 2*d.
   function automatic logic model_out(input int d, input int sd, input int rises, input logic clk);
      int h;
      if (rises <= sd) return 1'b0;
      h = 2 * (rises - sd - 1) + (clk ? 0 : 1);
      return (h % (2 * d)) < d;
   endfunction

   logic [3:0] exp_q[$];
   int         rises    = 0;
   logic       prev_clk = 1'b0;

   initial begin
      forever begin
         @(clock or reset);
         if (reset) rises = 0;
         else if (clock && !prev_clk) rises++;
         prev_clk = clock;
         exp_q.push_back({model_out(4, 2, rises, clock), model_out(3, 0, rises, clock),
                          model_out(2, 0, rises, clock), model_out(5, 1, rises, clock)});
      end
   end

   // Monitor: mid-way between clock edges, compare against the newest expectation.
   initial begin
      logic [3:0] exp;
      forever begin
         @(clock);
         #0.5;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty @%0t: no expectation queued", $time);
         end else begin
            while (exp_q.size() > 1) void'(exp_q.pop_front());
            exp = exp_q.pop_front();
            check_vec("scoreboard", {co4, co3, co2, co5}, exp);
         end
      end
   end

   // Pulse-width checks; edges caused by reset, or spanning one, are skipped.
   real r3_t, f3_t, r5_t, f5_t;
   int  r3_ep = -1, f3_ep = -1, r5_ep = -1, f5_ep = -1;
   bit  r3_ok, f3_ok, r5_ok, f5_ok;

   always @(posedge co3) begin
      if (!reset && f3_ok && f3_ep == epoch) check_real("d3_low_time", $realtime - f3_t, 3.0);
      r3_t = $realtime; r3_ok = !reset; r3_ep = epoch;
   end

   always @(negedge co3) begin
      if (!reset && r3_ok && r3_ep == epoch) check_real("d3_high_time", $realtime - r3_t, 3.0);
      f3_t = $realtime; f3_ok = !reset; f3_ep = epoch;
   end

   always @(posedge co5) begin
      if (!reset && f5_ok && f5_ep == epoch) check_real("d5_low_time", $realtime - f5_t, 5.0);
      if (count_on) pulses5++;
      r5_t = $realtime; r5_ok = !reset; r5_ep = epoch;
   end

   always @(negedge co5) begin
      if (!reset && r5_ok && r5_ep == epoch) check_real("d5_high_time", $realtime - r5_t, 5.0);
      f5_t = $realtime; f5_ok = !reset; f5_ep = epoch;
   end

   // Release just after a falling edge, i.e. ahead of the next rising edge.
   task automatic release_reset();
      @(negedge clock);
      #0.25;
      reset = 1'b0;
   endtask

   initial begin
      bit found;
      repeat (3) @(posedge clock);
      for (int it = 0; it < 6; it++) begin
         release_reset();
         repeat ($urandom_range(20, 60)) @(posedge clock);
         found = 1'b0;
         for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clock);
            found = co4;
         end
         check_int("d4_high_phase_found", int'(found), 1);
         #0.25;
         epoch++;
         reset = 1'b1;
         #0.1;
         check_vec("async_reset_mid_high", {co4, co3, co2, co5}, 4'b0000);
         repeat ($urandom_range(5, 8)) @(negedge clock);
      end

      release_reset();
      count_on = 1'b1;
      #200;
      count_on = 1'b0;
      check_int("d5_pulses_in_100_clocks", pulses5, 20);
      repeat (20) @(posedge clock);
      #0.5;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
